bs_job_arbiter: RTL and testbench
=================================

Name: bs_job_arbiter

Overview:
- Shares one black_scholes pricing core between NUM_REQ requesters (for example the SPI front end and a batch loader).
- Arbitrates round-robin and latches the winning parameter set.
- Sequences the core's start/done handshake, applies a watchdog timeout, and returns each result tagged with the requester ID over a valid/ready response channel.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
W, 16, width of each operand and of the result
TIMEOUT, 1024, core cycles allowed from start to done before the job is aborted (>=4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_params  in  NUM_REQ*5*W  per-requester {S,K,r,sigma,T}; requester i occupies slice [i*5W +: 5W], S in the MSBs
bs_start  out  1  one-cycle start pulse to core
bs_S, bs_K, bs_r, bs_sigma, bs_T  out  W each  operands to core
bs_done  in  1  core completion pulse
bs_call_price  in  W  core result, valid while bs_done=1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  clog2(NUM_REQ) (min 1)  requester index of the job
rsp_price  out  W  call price; 0 when rsp_timeout=1
rsp_timeout  out  1  job was aborted by the watchdog
busy  out  1  high in every state except IDLE
stale_cnt  out  8  saturating count of ignored bs_done pulses

Behaviour:
- Reset: all outputs 0, operand registers 0, round-robin pointer 0, FSM in IDLE. Reset mid-job abandons the job silently; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Grant = first i with req_valid[i]=1, searching from the pointer upward and wrapping.
  - req_ready[grant]=1 combinationally, only in IDLE; all req_ready bits are 0 in every other state.
  - On accept (valid&ready): latch the 5 operands and the ID, set pointer=(grant+1) mod NUM_REQ, go to ISSUE.
  - No valid request: stay in IDLE, pointer unchanged.
- ISSUE: bs_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - bs_done=1: capture bs_call_price, rsp_timeout=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_price=0, rsp_timeout=1, go to RESP.
  - bs_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_price and rsp_timeout held stable until rsp_ready=1.
  - The cycle with rsp_valid&rsp_ready is the last RESP cycle; next state is IDLE. A new grant can occur the cycle after.
- Operands: bs_S..bs_T are driven from the latched registers and stay stable from ISSUE through RESP.
- Stale done: bs_done seen in IDLE, ISSUE or RESP is ignored and increments stale_cnt, which saturates at 255. This covers a late done after a timeout.
- Latency: accept at cycle t; bs_start at t+1; core done at cycle d (d>=t+2) gives rsp_valid at d+1.
- Throughput: at most one job in flight; no queuing inside the block.
- Requester rules: may change req_params freely while not accepted. Must hold req_valid until accepted; this is not checked.

Test Plan:
- Single job: req0 valid with S=100,K=95,r=5,sigma=20,T=1; core model returns done 10 cycles after start with price 0x0123 -> req_ready[0] for one cycle; bs_start pulse 1 cycle later; rsp_valid, rsp_id=0, rsp_price=0x0123, rsp_timeout=0 one cycle after done.
- Round-robin: req0 and req1 both held valid for 4 jobs -> grant order 0,1,0,1; pointer wraps correctly.
- Backpressure: rsp_ready held 0 for 20 cycles -> rsp fields stable, busy=1, no req_ready asserted; both requesters are granted only after the response handshake.
- Timeout: TIMEOUT=16, core never asserts done -> rsp_valid exactly 16 cycles after bs_start with rsp_timeout=1, rsp_price=0. A done injected 5 cycles later gives stale_cnt=1 and no response.
- Simultaneous done and timeout: done arrives on the TIMEOUT-1 cycle with price 0x0042 -> rsp_timeout=0, rsp_price=0x0042.
- Async reset asserted during WAIT -> all outputs 0 immediately, no response afterwards; the next job after reset is granted to requester 0 first.

Source files
------------

// File: rtl/bs_job_arbiter.sv
// bs_job_arbiter: shares one Black-Scholes pricing core between NUM_REQ
// requesters. It picks requesters in round-robin order, latches the
// winner's operand set, sequences the core start/done handshake under a
// watchdog, and returns each result tagged with the requester ID over a
// valid/ready response channel. Only one job is in flight at a time.
module bs_job_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 1024,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*5*W-1:0] req_params,
  output logic                   bs_start,
  output logic [W-1:0]           bs_S,
  output logic [W-1:0]           bs_K,
  output logic [W-1:0]           bs_r,
  output logic [W-1:0]           bs_sigma,
  output logic [W-1:0]           bs_T,
  input  logic                   bs_done,
  input  logic [W-1:0]           bs_call_price,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [W-1:0]           rsp_price,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [7:0]             stale_cnt
);

  // Watchdog counter is wide enough to hold TIMEOUT-1.
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    s_q;
  logic [W-1:0]    k_q;
  logic [W-1:0]    r_q;
  logic [W-1:0]    sigma_q;
  logic [W-1:0]    t_q;
  logic            bs_start_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_price_q;
  logic            rsp_timeout_q;
  logic            busy_q;
  logic [7:0]      stale_q;

  logic            gnt_found_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [IDW-1:0]  ptr_d;
  logic [5*W-1:0]  params_s;
  logic [CW-1:0]   cnt_d;
  logic            wd_expired_s;
  logic            accept_s;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found_s && req_valid[idx_v]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = idx_v[IDW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Accept strobe, grant-side operand slice and the pointer value after this grant.
  always_comb begin
    accept_s = (state_q == IDLE) && gnt_found_s;
    params_s = req_params[int'(gnt_idx_s)*5*W +: 5*W];
    if (gnt_idx_s == IDW'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_s + IDW'(1);
    end
  end

  // Ready goes only to the current winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (accept_s && !rst) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Watchdog: the incremented count reaching TIMEOUT-1 ends the wait.
  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    wd_expired_s = (cnt_d == CW'(TIMEOUT - 1));
  end

  // Job sequencer with registered outputs, operand latch and stale-done counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      s_q           <= '0;
      k_q           <= '0;
      r_q           <= '0;
      sigma_q       <= '0;
      t_q           <= '0;
      bs_start_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_price_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      stale_q       <= 8'd0;
    end else begin
      bs_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            s_q        <= params_s[5*W-1 -: W];
            k_q        <= params_s[4*W-1 -: W];
            r_q        <= params_s[3*W-1 -: W];
            sigma_q    <= params_s[2*W-1 -: W];
            t_q        <= params_s[W-1:0];
            id_q       <= gnt_idx_s;
            ptr_q      <= ptr_d;
            bs_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            state_q    <= IDLE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A done in the same cycle as watchdog expiry takes priority.
          if (bs_done) begin
            rsp_price_q   <= bs_call_price;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (wd_expired_s) begin
            rsp_price_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q         <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase

      // A done pulse outside WAIT belongs to no live job (e.g. late after a timeout).
      if (bs_done && (state_q != WAIT) && (stale_q != 8'hFF)) begin
        stale_q <= stale_q + 8'd1;
      end else begin
        stale_q <= stale_q;
      end
    end
  end

  assign bs_start    = bs_start_q;
  assign bs_S        = s_q;
  assign bs_K        = k_q;
  assign bs_r        = r_q;
  assign bs_sigma    = sigma_q;
  assign bs_T        = t_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_price   = rsp_price_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign stale_cnt   = stale_q;

endmodule

// File: tb/tb_bs_job_arbiter.sv
// Randomized and directed bench for bs_job_arbiter. A timestamp-based job
// model (accept cycle, start cycle, deadline) predicts every output each cycle.
module tb_bs_job_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 16;
  localparam int TO   = 16;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*5*W-1:0] req_params = '0;
  logic                bs_start;
  logic [W-1:0]        bs_S, bs_K, bs_r, bs_sigma, bs_T;
  logic                bs_done = 1'b0;
  logic [W-1:0]        bs_call_price = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_price;
  logic                rsp_timeout;
  logic                busy;
  logic [7:0]          stale_cnt;

  always #5 clk = ~clk;

  bs_job_arbiter #(.NUM_REQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_params(req_params),
    .bs_start(bs_start), .bs_S(bs_S), .bs_K(bs_K), .bs_r(bs_r),
    .bs_sigma(bs_sigma), .bs_T(bs_T),
    .bs_done(bs_done), .bs_call_price(bs_call_price),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_price(rsp_price), .rsp_timeout(rsp_timeout),
    .busy(busy), .stale_cnt(stale_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_id = 0;
  logic [W-1:0] m_ops [5];
  int          m_start = -100;
  bit          m_pend = 0;
  logic [W-1:0] m_price = '0;
  bit          m_to = 0;
  int          m_stale = 0;
  int          done_cyc = -1;

  // stimulus controls
  bit [NREQ-1:0] req_force = '0;
  bit [NREQ-1:0] req_hold = '0;
  bit            rand_en = 0;
  int            rdy_mode = 0;      // 0: always ready, 1: never, 2: random
  int            lat_sel = 3;       // <0 random, 0 never done, >0 fixed latency
  bit            use_fix_price = 0;
  logic [W-1:0]  fix_price = '0;
  bit            stray_force = 0;
  bit            fixed_params = 0;
  logic [W-1:0]  fix_vals [5];
  logic [W-1:0]  prm [NREQ][5];

  // observations
  int           obs_start = -1;
  int           obs_rsp = -1;
  logic [W-1:0] obs_price = '0;
  logic         obs_to = 1'b0;
  int           obs_id = -1;
  int           grant_q [$];
  int           stale_before = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_grant(input bit [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic clear_obs();
    obs_start = -1;
    obs_rsp   = -1;
    obs_id    = -1;
    grant_q.delete();
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step();
    bit in_wait;
    bit idle;
    int g;
    int lat;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0] pr;
    idle    = !m_busy;
    in_wait = m_busy && !m_pend && (cyc > m_start);

    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("bs_start", 32'(bs_start), 32'(m_busy && (cyc == m_start)));
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    check_val("stale_cnt", 32'(stale_cnt), 32'(m_stale));
    if (m_pend) begin
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
      check_val("rsp_price", 32'(rsp_price), 32'(m_price));
      check_val("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
    end
    if (m_busy) begin
      check_val("bs_S", 32'(bs_S), 32'(m_ops[0]));
      check_val("bs_K", 32'(bs_K), 32'(m_ops[1]));
      check_val("bs_r", 32'(bs_r), 32'(m_ops[2]));
      check_val("bs_sigma", 32'(bs_sigma), 32'(m_ops[3]));
      check_val("bs_T", 32'(bs_T), 32'(m_ops[4]));
    end
    if (bs_start === 1'b1 && obs_start < 0) obs_start = cyc;
    if (rsp_valid === 1'b1 && obs_rsp < 0) begin
      obs_rsp   = cyc;
      obs_price = rsp_price;
      obs_to    = rsp_timeout;
      obs_id    = int'(rsp_id);
    end

    // core model: schedule the done pulse when the job starts
    if (m_busy && cyc == m_start) begin
      if (lat_sel >= 0) lat = lat_sel;
      else if ($urandom_range(0, 7) == 0) lat = 0;
      else lat = $urandom_range(1, TO + 3);
      done_cyc = (lat == 0) ? -1 : cyc + lat;
    end
    bs_done = ((done_cyc >= 0) && (cyc == done_cyc)) || stray_force ||
              (rand_en && ($urandom_range(0, 31) == 0));
    pr = use_fix_price ? fix_price : W'($urandom);
    bs_call_price = pr;

    for (int i = 0; i < NREQ; i++) begin
      if (!req_hold[i] && (req_force[i] || (rand_en && $urandom_range(0, 3) == 0)))
        req_hold[i] = 1'b1;
      for (int j = 0; j < 5; j++) begin
        prm[i][j] = fixed_params ? fix_vals[j] : W'($urandom);
        req_params[i*5*W + (4-j)*W +: W] = prm[i][j];
      end
    end
    req_valid = req_hold;
    if (rdy_mode == 0) rsp_ready = 1'b1;
    else if (rdy_mode == 1) rsp_ready = 1'b0;
    else rsp_ready = 1'($urandom_range(0, 1));

    #1;
    g = idle ? model_grant(req_hold) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) grant_q.push_back(i);

    // model advance for the coming edge
    if (bs_done && !in_wait && m_stale < 255) m_stale++;
    if (g >= 0) begin
      m_busy  = 1;
      m_id    = g;
      for (int j = 0; j < 5; j++) m_ops[j] = prm[g][j];
      m_ptr   = (g + 1) % NREQ;
      m_start = cyc + 1;
      m_pend  = 0;
      req_hold[g] = 1'b0;
    end else if (in_wait) begin
      if (bs_done) begin
        m_pend = 1; m_price = pr; m_to = 0;
      end else if (cyc == m_start + TO - 1) begin
        m_pend = 1; m_price = '0; m_to = 1;
      end
    end else if (m_pend && rsp_ready) begin
      m_busy = 0;
      m_pend = 0;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_bs_start", 32'(bs_start), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_rsp_price", 32'(rsp_price), 32'd0);
    check_val("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_val("rst_stale", 32'(stale_cnt), 32'd0);
    check_val("rst_ops", 32'({bs_S, bs_K}), 32'd0);
    check_val("rst_ops2", 32'({bs_r, bs_sigma}), 32'd0);
    check_val("rst_ops3", 32'(bs_T), 32'd0);
    m_busy = 0; m_pend = 0; m_ptr = 0; m_stale = 0; done_cyc = -1; m_start = -100;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    fix_vals[0] = 16'd100; fix_vals[1] = 16'd95; fix_vals[2] = 16'd5;
    fix_vals[3] = 16'd20;  fix_vals[4] = 16'd1;
    for (int j = 0; j < 5; j++) m_ops[j] = '0;
    @(negedge clk);
    do_reset();

    // round-robin with requesters 0 and 1 held valid
    clear_obs();
    rdy_mode = 0; lat_sel = 3; req_force = 3'b011;
    steps(40);
    check_val("rr_g0", 32'(grant_q.size() > 0 ? grant_q[0] : 99), 32'd0);
    check_val("rr_g1", 32'(grant_q.size() > 1 ? grant_q[1] : 99), 32'd1);
    check_val("rr_g2", 32'(grant_q.size() > 2 ? grant_q[2] : 99), 32'd0);
    check_val("rr_g3", 32'(grant_q.size() > 3 ? grant_q[3] : 99), 32'd1);
    req_force = '0;
    steps(20);

    // single job from requester 0, done 10 cycles after start
    clear_obs();
    fixed_params = 1; lat_sel = 10; use_fix_price = 1; fix_price = 16'h0123;
    req_force = 3'b001;
    step();
    req_force = '0;
    steps(20);
    check_val("single_grant", 32'(grant_q.size() > 0 ? grant_q[0] : 99), 32'd0);
    check_val("single_lat", 32'(obs_rsp - obs_start), 32'd11);
    check_val("single_price", 32'(obs_price), 32'h0123);
    check_val("single_to", 32'(obs_to), 32'd0);
    check_val("single_id", 32'(obs_id), 32'd0);

    // backpressure: response held off for a long time
    clear_obs();
    fixed_params = 0; use_fix_price = 0; lat_sel = 2; rdy_mode = 1; req_force = 3'b011;
    steps(30);
    check_val("bp_grants_held", 32'(grant_q.size()), 32'd1);
    rdy_mode = 0;
    steps(3);
    check_val("bp_grants_after", 32'(grant_q.size()), 32'd2);
    req_force = '0;
    steps(20);

    // watchdog timeout, then a late done becomes stale
    clear_obs();
    lat_sel = 0; req_force = 3'b001;
    step();
    req_force = '0;
    steps(20);
    check_val("to_lat", 32'(obs_rsp - obs_start), 32'(TO));
    check_val("to_flag", 32'(obs_to), 32'd1);
    check_val("to_price", 32'(obs_price), 32'd0);
    stale_before = m_stale;
    stray_force = 1;
    step();
    stray_force = 0;
    steps(3);
    check_val("to_stale", 32'(stale_cnt), 32'(stale_before + 1));

    // done on the last allowed cycle beats the watchdog
    clear_obs();
    lat_sel = TO - 1; use_fix_price = 1; fix_price = 16'h0042; req_force = 3'b001;
    step();
    req_force = '0;
    steps(22);
    check_val("sim_to", 32'(obs_to), 32'd0);
    check_val("sim_price", 32'(obs_price), 32'h0042);
    check_val("sim_lat", 32'(obs_rsp - obs_start), 32'(TO));

    // randomized traffic
    use_fix_price = 0; lat_sel = -1; rdy_mode = 2; rand_en = 1;
    steps(3000);
    rand_en = 0; rdy_mode = 0;
    steps(40);

    // stale counter saturation
    stray_force = 1;
    steps(260);
    stray_force = 0;
    check_val("stale_sat", 32'(stale_cnt), 32'd255);

    // reset during WAIT: job abandoned, requester 0 first afterwards
    lat_sel = 0; req_force = 3'b011;
    steps(5);
    do_reset();
    clear_obs();
    lat_sel = 3;
    steps(3);
    check_val("rst_first_grant", 32'(grant_q.size() > 0 ? grant_q[0] : 99), 32'd0);
    req_force = '0;
    steps(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
